// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2
  } state_e;

  localparam int          IFQ_DEPTH = 2;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/ifetch_skid_fifo.sv
// Two-entry FIFO of {pc, instr} between the memory return path and decode.
// Flush wins over a simultaneous push; the top never pops empty or pushes full without a pop.
module ifetch_skid_fifo
  import ifetch_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] entry_reg [IFQ_DEPTH];
  logic             rd_ptr_reg;
  logic             wr_ptr_reg;
  logic [1:0]       count_reg;

  // Entries hold no reset value; the top masks the head while the queue is empty.
  generate
    for (genvar gi = 0; gi < IFQ_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
          entry_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = entry_reg[rd_ptr_reg];
  assign occupancy = count_reg;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: PC ownership, single in-flight synchronous read, 2-deep buffer, redirect/halt.
// Define IFETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module instr_fetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          data_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] ADDR_Prog,
  input  logic [data_WIDTH-1:0] mem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [data_WIDTH-1:0] instr,
  output logic [31:0]           instr_pc,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt_req,
  output logic                  halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  logic [31:0] pc_reg;
  logic [31:0] fetch_pc_reg;
  logic        inflight_reg;
  state_e      state_reg;
  state_e      state_next;

  logic [1:0]                 occupancy;
  logic [32+data_WIDTH-1:0]   head_data;
  logic                       pop;
  logic                       issue;
  logic [2:0]                 demand;

  assign instr_valid = (occupancy != 2'd0);
  assign pop         = instr_valid & instr_ready;

  // Slots already claimed after this edge: buffered + returning - leaving.
  assign demand = {1'b0, occupancy} + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue  = (state_reg == RUN) && !redirect_valid && (demand < 3'(IFQ_DEPTH));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (halt_req) state_next = HALTING;
      HALTING: if (!halt_req) state_next = RUN;
               else if (!inflight_reg) state_next = HALTED;
      HALTED:  if (!halt_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      fetch_pc_reg <= 32'd0;
      inflight_reg <= 1'b0;
      state_reg    <= RUN;
    end else begin
      state_reg <= state_next;
      if (redirect_valid) begin
        pc_reg       <= redirect_pc & ~32'd3;
        inflight_reg <= 1'b0;
      end else begin
        inflight_reg <= issue;
        if (issue) begin
          pc_reg       <= pc_reg + PC_STEP;
          fetch_pc_reg <= pc_reg;
        end
      end
    end
  end

  // Redirect flushes the queue, which also drops the word returning this cycle.
  ifetch_skid_fifo #(
    .WIDTH(32 + data_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (inflight_reg),
    .push_data ({fetch_pc_reg, mem_data}),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  assign ADDR_Prog = pc_reg[ADDR_WIDTH+1:2];
  assign instr     = instr_valid ? head_data[data_WIDTH-1:0] : '0;
  assign instr_pc  = instr_valid ? head_data[32+data_WIDTH-1:data_WIDTH] : 32'd0;
  assign halted    = (state_reg == HALTED);

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_reg <= 32'd0;
      perf_stall_reg   <= 32'd0;
    end else begin
      if (pop) perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (instr_valid && !instr_ready) perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`endif

endmodule
